// File: rtl/rst_seq_sync_if.sv
// Reset-sequencer output bundle: per-channel active-low resets, the all-released flag and FSM state.
// The sw_rst request only exists when RST_SEQ_SW_RST_EN is defined.
`timescale 1ns/1ps
interface rst_seq_sync_if #(
  parameter int NUM_CH = 3
);
  // Level signals, no handshake: sync_rst/all_released are valid every cycle, sw_rst is sampled every edge.
`ifdef RST_SEQ_SW_RST_EN
  logic              sw_rst;
`endif
  logic [NUM_CH-1:0] sync_rst;
  logic              all_released;
  logic [1:0]        state;

  modport master (
`ifdef RST_SEQ_SW_RST_EN
    input  sw_rst,
`endif
    output sync_rst,
    output all_released,
    output state
  );

  modport slave (
`ifdef RST_SEQ_SW_RST_EN
    output sw_rst,
`endif
    input  sync_rst,
    input  all_released,
    input  state
  );
endinterface

// File: rtl/rst_seq_sync.sv
// Reset synchronizer and sequencer: async assert, sync ordered release of NUM_CH resets.
// Optional soft reset restart enabled by defining RST_SEQ_SW_RST_EN.
`timescale 1ns/1ps
module rst_seq_sync #(
  parameter int NUM_STAGES     = 2,
  parameter int NUM_CH         = 3,
  parameter int STRETCH_CYCLES = 8,
  parameter int GAP_CYCLES     = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  rst_seq_sync_if.master bus
);

  localparam int MAX_CYC = (STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_t;

  logic [NUM_STAGES-1:0] chain;
  logic                  sync_n;
  logic                  sw_req;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [NUM_CH-1:0] rel, rel_nxt;
  logic              all, all_nxt;

`ifdef RST_SEQ_SW_RST_EN
  assign sw_req = bus.sw_rst;
`else
  assign sw_req = 1'b0;
`endif

  // Metastability on rst_n release is absorbed here; D is a constant 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[NUM_STAGES-2:0], 1'b1};
  end
  assign sync_n = chain[NUM_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HOLD;
      cnt   <= '0;
      idx   <= '0;
      rel   <= '0;
      all   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      rel   <= rel_nxt;
      all   <= all_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    rel_nxt   = rel;
    all_nxt   = all;
    case (state)
      HOLD: begin
        if (sync_n) begin
          state_nxt = STRETCH;
          cnt_nxt   = '0;
        end
      end
      STRETCH: begin
        if (cnt == CNT_W'(STRETCH_CYCLES - 1)) begin
          rel_nxt[0] = 1'b1;
          cnt_nxt    = '0;
          idx_nxt    = IDX_W'(1);
          if (NUM_CH == 1) begin
            all_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = RELEASE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          rel_nxt[idx] = 1'b1;
          cnt_nxt      = '0;
          idx_nxt      = idx + IDX_W'(1);
          if (idx == IDX_W'(NUM_CH - 1)) begin
            all_nxt   = 1'b1;
            state_nxt = DONE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
    // Soft reset restarts the stretch phase; the sync chain and HOLD are untouched.
    if (sw_req && (state != HOLD)) begin
      rel_nxt   = '0;
      all_nxt   = 1'b0;
      state_nxt = STRETCH;
      cnt_nxt   = '0;
      idx_nxt   = IDX_W'(1);
    end
  end

  assign bus.sync_rst     = rel;
  assign bus.all_released = all;
  assign bus.state        = state;

endmodule
